serial_frame_receiver: RTL and testbench



---
 rtl/serial_frame_receiver_pkg.sv | 16 +
 rtl/serial_frame_receiver_bit_timer.sv | 34 +++
 rtl/serial_frame_receiver.sv | 97 +++++++++
 tb/tb_serial_frame_receiver.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/serial_frame_receiver_pkg.sv
// Shared definitions for the serial frame receiver: FSM encodings and the
// counter width helper used by the bit timer.
package serial_frame_receiver_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  function automatic int cnt_width(input int bit_cycles);
    return (bit_cycles > 1) ? $clog2(bit_cycles) : 1;
  endfunction

endpackage

// File: rtl/serial_frame_receiver_bit_timer.sv
// Per-bit cycle counter: flags the mid-bit point of the start bit and the
// end of every full bit period, wrapping to zero at each sample point.
module bit_timer
  import serial_frame_receiver_pkg::*;
#(
  parameter int BIT_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic tick_half,
  output logic tick_full
);

  localparam int CW = cnt_width(BIT_CYCLES);
  localparam int H  = BIT_CYCLES / 2;

  logic [CW-1:0] cnt;

  assign tick_half = (cnt == CW'(H - 1));
  assign tick_full = (cnt == CW'(BIT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear || tick_full) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/serial_frame_receiver.sv
// Serial frame receiver: finds a start bit, shifts in WIDTH data bits MSB
// first, checks the stop bit and publishes the word with a one-cycle pulse.
module serial_frame_receiver
  import serial_frame_receiver_pkg::*;
#(
  parameter int WIDTH      = 4,
  parameter int BIT_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             EN,
  input  logic             SI,
  output logic [WIDTH-1:0] Q,
  output logic             V,
  output logic             FE,
  output logic             BUSY
);

  localparam int BW = $clog2(WIDTH);

  state_t          state, next_state;
  logic [WIDTH-1:0] sr;
  logic [BW-1:0]    bitn;
  logic             tick_half, tick_full;
  logic             timer_clear, timer_en;
  logic             do_shift, stop_good, stop_bad, last_bit;

  assign last_bit = (bitn == BW'(WIDTH - 1));

  bit_timer #(
    .BIT_CYCLES(BIT_CYCLES)
  ) u_bit_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (timer_clear),
    .enable   (timer_en),
    .tick_half(tick_half),
    .tick_full(tick_full)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Dropping EN abandons any partial frame regardless of state.
  always_comb begin
    next_state = state;
    if (!EN) begin
      next_state = IDLE;
    end else begin
      case (state)
        IDLE:    if (!SI) next_state = START;
        START:   if (tick_half) next_state = SI ? IDLE : DATA;
        DATA:    if (tick_full && last_bit) next_state = STOP;
        STOP:    if (tick_full) next_state = IDLE;
        default: next_state = IDLE;
      endcase
    end
  end

  always_comb begin
    BUSY        = (state != IDLE);
    timer_en    = EN && (state != IDLE);
    timer_clear = !EN || (state == IDLE) || ((state == START) && tick_half);
    do_shift    = EN && (state == DATA) && tick_full;
    stop_good   = EN && (state == STOP) && tick_full && SI;
    stop_bad    = EN && (state == STOP) && tick_full && !SI;
  end

  // Pulses last exactly one cycle since STOP always exits on the sample edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr   <= '0;
      bitn <= '0;
      Q    <= '0;
      V    <= 1'b0;
      FE   <= 1'b0;
    end else begin
      V  <= stop_good;
      FE <= stop_bad;
      if (stop_good) begin
        Q <= sr;
      end
      if (do_shift) begin
        sr   <= {sr[WIDTH-2:0], SI};
        bitn <= last_bit ? '0 : bitn + 1'b1;
      end else if (state == IDLE) begin
        bitn <= '0;
      end
    end
  end

endmodule

// File: tb/tb_serial_frame_receiver.sv
// Directed self-checking bench for serial_frame_receiver with the default
// WIDTH=4 / BIT_CYCLES=4 geometry.
module tb_serial_frame_receiver;

  localparam int WIDTH      = 4;
  localparam int BIT_CYCLES = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             EN;
  logic             SI;
  logic [WIDTH-1:0] Q;
  logic             V;
  logic             FE;
  logic             BUSY;

  int assertCount = 0;
  int failCount   = 0;
  int vSeen       = 0;
  int feSeen      = 0;
  int v0, f0;

  serial_frame_receiver #(
    .WIDTH     (WIDTH),
    .BIT_CYCLES(BIT_CYCLES)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .EN   (EN),
    .SI   (SI),
    .Q    (Q),
    .V    (V),
    .FE   (FE),
    .BUSY (BUSY)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (V) vSeen++;
    if (FE) feSeen++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Drives one full frame; edge offset e counts from t0 (the start-detect edge).
  task automatic applyStimulus(input logic [3:0] data, input logic stopBit,
                               input logic [3:0] expQ, input logic expV,
                               input logic expFE, input string tag);
    logic [5:0] bits;
    bits = {stopBit, data[0], data[1], data[2], data[3], 1'b0};
    for (int e = 0; e < 24; e++) begin
      SI = bits[e / BIT_CYCLES];
      tick();
      if (e == 0) checkOutput({tag, "_busy_rise"}, 32'(BUSY), 32'd1);
      if (e == 21) begin
        checkOutput({tag, "_busy_late"}, 32'(BUSY), 32'd1);
        checkOutput({tag, "_v_early"}, 32'(V), 32'd0);
        checkOutput({tag, "_fe_early"}, 32'(FE), 32'd0);
      end
      if (e == 22) begin
        checkOutput({tag, "_v"}, 32'(V), 32'(expV));
        checkOutput({tag, "_fe"}, 32'(FE), 32'(expFE));
        checkOutput({tag, "_q"}, 32'(Q), 32'(expQ));
        checkOutput({tag, "_busy_fall"}, 32'(BUSY), 32'd0);
      end
      if (e == 23) begin
        checkOutput({tag, "_v_clear"}, 32'(V), 32'd0);
        checkOutput({tag, "_fe_clear"}, 32'(FE), 32'd0);
      end
    end
    SI = 1'b1;
  endtask

  initial begin
    logic [5:0] bits5;
    logic [5:0] bitsF;
    bits5 = {1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    bitsF = {1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

    EN    = 1'b0;
    SI    = 1'b1;
    rst_n = 1'b0;
    tick();
    tick();
    checkOutput("reset_q", 32'(Q), 32'd0);
    checkOutput("reset_v", 32'(V), 32'd0);
    checkOutput("reset_fe", 32'(FE), 32'd0);
    checkOutput("reset_busy", 32'(BUSY), 32'd0);
    rst_n = 1'b1;
    EN    = 1'b1;
    repeat (3) tick();

    applyStimulus(4'hC, 1'b1, 4'hC, 1'b1, 1'b0, "good");
    applyStimulus(4'hC, 1'b1, 4'hC, 1'b1, 1'b0, "b2b_first");
    applyStimulus(4'h3, 1'b1, 4'h3, 1'b1, 1'b0, "b2b_second");
    repeat (2) tick();

    // Start bit only one cycle long: rejected at the mid-bit sample.
    v0 = vSeen;
    f0 = feSeen;
    SI = 1'b0;
    tick();
    SI = 1'b1;
    tick();
    checkOutput("glitch_busy", 32'(BUSY), 32'd1);
    tick();
    checkOutput("glitch_idle", 32'(BUSY), 32'd0);
    repeat (8) tick();
    checkOutput("glitch_no_v", 32'(vSeen - v0), 32'd0);
    checkOutput("glitch_no_fe", 32'(feSeen - f0), 32'd0);
    checkOutput("glitch_q", 32'(Q), 32'h3);

    applyStimulus(4'hA, 1'b0, 4'h3, 1'b0, 1'b1, "bad_stop");
    repeat (2) tick();

    v0 = vSeen;
    f0 = feSeen;
    for (int e = 0; e < 10; e++) begin
      SI = bits5[e / BIT_CYCLES];
      tick();
    end
    EN = 1'b0;
    SI = 1'b1;
    tick();
    checkOutput("en_drop_busy", 32'(BUSY), 32'd0);
    repeat (2) tick();
    EN = 1'b1;
    repeat (4) tick();
    checkOutput("en_idle_busy", 32'(BUSY), 32'd0);
    checkOutput("en_no_v", 32'(vSeen - v0), 32'd0);
    checkOutput("en_no_fe", 32'(feSeen - f0), 32'd0);
    checkOutput("en_q", 32'(Q), 32'h3);
    applyStimulus(4'h5, 1'b1, 4'h5, 1'b1, 1'b0, "after_en");

    v0 = vSeen;
    f0 = feSeen;
    for (int e = 0; e < 12; e++) begin
      SI = bitsF[e / BIT_CYCLES];
      tick();
    end
    rst_n = 1'b0;
    #1;
    checkOutput("midreset_q", 32'(Q), 32'd0);
    checkOutput("midreset_v", 32'(V), 32'd0);
    checkOutput("midreset_fe", 32'(FE), 32'd0);
    checkOutput("midreset_busy", 32'(BUSY), 32'd0);
    #2;
    SI    = 1'b1;
    rst_n = 1'b1;
    repeat (3) tick();
    checkOutput("postreset_busy", 32'(BUSY), 32'd0);
    checkOutput("postreset_no_v", 32'(vSeen - v0), 32'd0);
    checkOutput("postreset_no_fe", 32'(feSeen - f0), 32'd0);
    applyStimulus(4'hF, 1'b1, 4'hF, 1'b1, 1'b0, "after_reset");
    repeat (2) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
